// File: rtl/series_accumulator.sv
// series_accumulator: sums NUM_TERMS Taylor terms into exp/sin/cos/sinh with a one-cycle done pulse.
// Define SERIES_SAT_EN to clamp result_q16 into [0, 0xFFFF] and flag ovf; otherwise result_q16 truncates.
module series_accumulator #(
    parameter int NUM_TERMS = 8,
    parameter int ACC_W     = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [15:0]      term,
    input  logic             term_valid,
    output logic             term_ready,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] result,
    output logic [15:0]      result_q16,
    output logic             ovf
);
    localparam int IW = NUM_TERMS > 1 ? $clog2(NUM_TERMS) : 1;
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    state_t           r_state;
    logic [IW-1:0]    r_idx;
    logic [1:0]       r_mode;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_result;
    logic [15:0]      r_q16;
    logic             r_pend;
    logic             r_done;
    logic             r_ovf;
    logic             w_accept;
    logic [1:0]       w_q;
    logic             w_pos;
    logic             w_neg;
    logic [ACC_W-1:0] w_ext;
    logic [ACC_W-1:0] w_next;
    logic [15:0]      w_q16;
    logic             w_ovf;

    assign term_ready = r_state == ACCUM;
    assign busy       = r_state == ACCUM;
    assign done       = r_done;
    assign result     = r_result;
    assign result_q16 = r_q16;
    assign ovf        = r_ovf;
    assign w_accept   = term_valid && term_ready;
    assign w_q        = 2'(r_idx);
    assign w_ext      = {{(ACC_W-16){1'b0}}, term};
    // Sign of the contribution follows the Taylor series pattern on idx mod 4
    assign w_pos  = r_mode == 2'd0 || (r_mode == 2'd3 && w_q[0]) ||
                    (r_mode == 2'd1 && w_q == 2'd1) || (r_mode == 2'd2 && w_q == 2'd0);
    assign w_neg  = (r_mode == 2'd1 && w_q == 2'd3) || (r_mode == 2'd2 && w_q == 2'd2);
    assign w_next = w_pos ? r_acc + w_ext : w_neg ? r_acc - w_ext : r_acc;

`ifdef SERIES_SAT_EN
    assign w_ovf = r_acc[ACC_W-1] || (|r_acc[ACC_W-2:16]);
    assign w_q16 = r_acc[ACC_W-1] ? 16'h0000 : w_ovf ? 16'hFFFF : r_acc[15:0];
`else
    assign w_ovf = 1'b0;
    assign w_q16 = r_acc[15:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_mode   <= 2'd0;
            r_acc    <= '0;
            r_result <= '0;
            r_q16    <= 16'h0000;
            r_pend   <= 1'b0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == ACCUM) begin
                if (w_accept) begin
                    r_acc <= w_next;
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == IW'(NUM_TERMS - 1)) begin
                        r_state <= DONE;
                        r_pend  <= 1'b1;
                    end
                end
            end else begin
                // Publish the finished sum one cycle after the last accept; a start in that same cycle still sees it
                if (r_pend) begin
                    r_result <= r_acc;
                    r_q16    <= w_q16;
                    r_ovf    <= w_ovf;
                    r_done   <= 1'b1;
                    r_pend   <= 1'b0;
                end
                if (start) begin
                    r_acc   <= '0;
                    r_idx   <= '0;
                    r_mode  <= mode;
                    r_state <= ACCUM;
                end
            end
        end
    end
endmodule

// File: tb/tb_series_accumulator.sv
// tb_series_accumulator: scoreboard bench comparing series_accumulator against a coefficient-based series model.
module tb_series_accumulator;
    localparam int N = 8;
    localparam int W = 20;
    typedef struct {
        logic [W-1:0] r;
        logic [15:0]  q;
        logic         o;
        int           c;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   mode = 2'd0;
    logic [15:0]  term = 16'h0000;
    logic         term_valid = 1'b0;
    logic         term_ready;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [15:0]  result_q16;
    logic         ovf;

    exp_t        sb[$];
    exp_t        me;
    logic [15:0] t[N];
    logic [1:0]  cur_mode;
    logic        prev_done = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    series_accumulator #(.NUM_TERMS(N), .ACC_W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .term(term),
        .term_valid(term_valid), .term_ready(term_ready), .busy(busy),
        .done(done), .result(result), .result_q16(result_q16), .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    // Each index carries a coefficient of +1, -1 or 0 depending on the function
    function automatic exp_t model(input logic [1:0] m);
        exp_t e;
        int s;
        int c;
        logic signed [W-1:0] rs;
        s = 0;
        for (int i = 0; i < N; i++) begin
            c = m == 2'd0 ? 1 : m == 2'd3 ? i % 2 :
                m == 2'd1 ? (i % 4 == 1 ? 1 : i % 4 == 3 ? -1 : 0) :
                            (i % 4 == 0 ? 1 : i % 4 == 2 ? -1 : 0);
            s += c * int'(t[i]);
        end
        e.r = s[W-1:0];
        rs = e.r;
`ifdef SERIES_SAT_EN
        e.q = rs < 0 ? 16'h0000 : rs > 65535 ? 16'hFFFF : e.r[15:0];
        e.o = rs < 0 || rs > 65535;
`else
        e.q = e.r[15:0];
        e.o = 1'b0;
`endif
        e.c = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no done (result %0h)", result);
            end else begin
                me = sb.pop_front();
                chk("result", 32'(result), 32'(me.r));
                chk("result_q16", 32'(result_q16), 32'(me.q));
                chk("ovf", 32'(ovf), 32'(me.o));
                chk("done_latency", cyc, me.c + 1);
                chk("done_width", 32'(prev_done), 32'd0);
            end
        end
        prev_done = done;
    end

    task automatic do_start(input logic [1:0] m, input logic v);
        start = 1'b1;
        mode = m;
        term_valid = v;
        term = 16'($urandom);
        @(negedge clk);
        start = 1'b0;
        term_valid = 1'b0;
        mode = 2'($urandom);
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic feed(input int i, input logic st);
        int k = 0;
        exp_t e;
        term = t[i];
        term_valid = 1'b1;
        start = st;
        if (st) mode = 2'($urandom);
        while (!term_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!term_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got term_ready=0 expected 1 at idx %0d", i);
            start = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        if (i == N - 1) begin
            e = model(cur_mode);
            e.c = cyc;
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic wait_sb();
        int k = 0;
        while (sb.size() > 0 && k < 10) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected result %0h", sb[0].r);
            sb.delete();
        end
    endtask

    task automatic run(input logic [1:0] m, input int bub, input logic sv);
        cur_mode = m;
        do_start(m, sv);
        for (int i = 0; i < N; i++) begin
            if ((bub == 1 && i > 0) || (bub == 2 && $urandom_range(0, 2) == 0)) begin
                term_valid = 1'b0;
                @(negedge clk);
            end
            feed(i, 1'b0);
        end
        term_valid = 1'b0;
        wait_sb();
    endtask

    task automatic chk_cleared(input string nm);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_ready"}, 32'(term_ready), 32'd0);
        chk({nm, "_done"}, 32'(done), 32'd0);
        chk({nm, "_result"}, 32'(result), 32'd0);
        chk({nm, "_q16"}, 32'(result_q16), 32'd0);
        chk({nm, "_ovf"}, 32'(ovf), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_cleared("reset");
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < N; i++) t[i] = 16'h1000;
        run(2'd0, 0, 1'b0);
        for (int i = 0; i < N; i++) t[i] = 16'(16'h0100 * (i + 1));
        run(2'd1, 0, 1'b0);
        for (int i = 0; i < N; i++) t[i] = 16'h7777;
        t[0] = 16'hFFFF;
        t[2] = 16'h2000;
        t[4] = 16'h0155;
        t[6] = 16'h0005;
        run(2'd2, 0, 1'b0);
        for (int i = 0; i < N; i++) t[i] = 16'h4000;
        run(2'd0, 1, 1'b0);
        for (int i = 0; i < N; i++) t[i] = 16'($urandom);
        cur_mode = 2'd1;
        do_start(2'd1, 1'b0);
        for (int i = 0; i < N; i++) feed(i, i == 3);
        term_valid = 1'b0;
        wait_sb();
        for (int i = 0; i < N; i++) t[i] = 16'($urandom);
        cur_mode = 2'd3;
        do_start(2'd3, 1'b0);
        for (int i = 0; i < 5; i++) feed(i, 1'b0);
        rst = 1'b1;
        term_valid = 1'b0;
        #1;
        chk_cleared("midrst");
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        run(2'd3, 0, 1'b0);
        for (int i = 0; i < N; i++) t[i] = 16'($urandom);
        run(2'd1, 0, 1'b1);
        repeat (24) begin
            for (int i = 0; i < N; i++) t[i] = 16'($urandom);
            run(2'($urandom_range(0, 3)), 2, 1'($urandom_range(0, 1)));
        end
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
